// File: rtl/reg_bus_master.sv
// Register-bus master: turns a queued command (address, length, direction,
// chip select) into SETUP / STROBE / HOLD beats on a simple parallel
// register bus. Bursts of 1..4 beats step the address modulo 2^SIZE.
//
// Command handshake: a command transfers on a rising Clk edge where both
// CmdValid and CmdReady are 1. CmdReady is high only while the master is
// idle and out of reset. The Cmd* inputs are sampled on that edge only and
// ignored at all other times.
module reg_bus_master #(
    parameter int SIZE          = 5,
    parameter int DATASIZE      = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                CmdValid,
    output logic                CmdReady,
    input  logic                CmdRW,
    input  logic                CmdChip,
    input  logic                CmdAB,
    input  logic [SIZE-1:0]     CmdAddr,
    input  logic [1:0]          CmdLen,
    input  logic [DATASIZE-1:0] CmdData,
    output logic [SIZE-1:0]     Address,
    output logic                RW,
    output logic [1:0]          CS,
    output logic                AB,
    output logic [DATASIZE-1:0] DataOut,
    input  logic [DATASIZE-1:0] DataIn,
    output logic [DATASIZE-1:0] RdData,
    output logic                RdValid,
    output logic                Done,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Counter value of the final strobe cycle of a beat.
    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [1:0]          beat_q, beat_d;
    logic [1:0]          len_q, len_d;
    logic                chip_q, chip_d;
    logic [SIZE-1:0]     addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [1:0]          cs_q, cs_d;
    logic                ab_q, ab_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic [DATASIZE-1:0] rd_q, rd_d;
    logic                rdv_q, rdv_d;
    logic                done_q, done_d;
    logic [1:0]          chip_sel;

    // Chip 0 maps to CS=01, chip 1 to CS=10; CS=11 is never produced.
    assign chip_sel = chip_q ? 2'b10 : 2'b01;

    assign CmdReady    = (state_q == IDLE) && Reset;
    assign Address     = addr_q;
    assign RW          = rw_q;
    assign CS          = cs_q;
    assign AB          = ab_q;
    assign DataOut     = dout_q;
    assign RdData      = rd_q;
    assign RdValid     = rdv_q;
    assign Done        = done_q;
    assign dbg_state_o = state_q;

    // Next-state and next-output logic; bus outputs are registered, so each
    // value is computed for the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        len_d   = len_q;
        chip_d  = chip_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        ab_d    = ab_q;
        dout_d  = dout_q;
        rd_d    = rd_q;
        cs_d    = 2'b00;
        rdv_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    state_d = SETUP;
                    chip_d  = CmdChip;
                    len_d   = CmdLen;
                    beat_d  = 2'd0;
                    addr_d  = CmdAddr;
                    rw_d    = CmdRW;
                    ab_d    = CmdAB;
                    if (!CmdRW) begin
                        dout_d = CmdData;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 3'd0;
                cs_d    = chip_sel;
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = 3'd0;
                    if (rw_q) begin
                        rd_d  = DataIn;
                        rdv_d = 1'b1;
                    end
                    done_d = (beat_q == len_q);
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    cs_d  = chip_sel;
                end
            end
            HOLD: begin
                if (beat_q != len_q) begin
                    state_d = SETUP;
                    beat_d  = beat_q + 2'd1;
                    addr_d  = addr_q + SIZE'(1);
                end else begin
                    state_d = IDLE;
                    rw_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus outputs; reset abandons any command in flight.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            beat_q  <= 2'd0;
            len_q   <= 2'd0;
            chip_q  <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            cs_q    <= 2'b00;
            ab_q    <= 1'b0;
            dout_q  <= '0;
            rd_q    <= '0;
            rdv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            chip_q  <= chip_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            cs_q    <= cs_d;
            ab_q    <= ab_d;
            dout_q  <= dout_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: a command-level model expands every accepted
// command into its per-cycle bus picture, one compare process checks the
// DUT against it each cycle, and directed tests pin key cycles with literals.
module tb_reg_bus_master;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int SC = 2;

  // clock / reset
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  // main DUT (STROBE_CYCLES = 2)
  logic          CmdValid, CmdReady, CmdRW, CmdChip, CmdAB;
  logic [AW-1:0] CmdAddr;
  logic [1:0]    CmdLen;
  logic [DW-1:0] CmdData;
  logic [AW-1:0] Address;
  logic          RW, AB, RdValid, Done;
  logic [1:0]    CS, dbg0;
  logic [DW-1:0] DataOut, DataIn, RdData;

  // second DUT (STROBE_CYCLES = 1)
  logic          s1_valid, s1_ready, s1_rw, s1_chip, s1_ab;
  logic [AW-1:0] s1_addr, s1_address;
  logic [1:0]    s1_len, s1_cs, dbg1;
  logic [DW-1:0] s1_data, s1_dout, s1_din, s1_rddata;
  logic          s1_rwo, s1_abo, s1_rdvalid, s1_done;

  // register file seen by the bus
  logic [DW-1:0] mem [0:31];
  assign DataIn = mem[Address];
  assign s1_din = mem[s1_address];

  reg_bus_master #(.SIZE(AW), .DATASIZE(DW), .STROBE_CYCLES(SC)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdRW(CmdRW), .CmdChip(CmdChip), .CmdAB(CmdAB), .CmdAddr(CmdAddr),
    .CmdLen(CmdLen), .CmdData(CmdData), .Address(Address), .RW(RW), .CS(CS),
    .AB(AB), .DataOut(DataOut), .DataIn(DataIn), .RdData(RdData),
    .RdValid(RdValid), .Done(Done), .dbg_state_o(dbg0)
  );

  reg_bus_master #(.SIZE(AW), .DATASIZE(DW), .STROBE_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .CmdValid(s1_valid), .CmdReady(s1_ready),
    .CmdRW(s1_rw), .CmdChip(s1_chip), .CmdAB(s1_ab), .CmdAddr(s1_addr),
    .CmdLen(s1_len), .CmdData(s1_data), .Address(s1_address), .RW(s1_rwo),
    .CS(s1_cs), .AB(s1_abo), .DataOut(s1_dout), .DataIn(s1_din),
    .RdData(s1_rddata), .RdValid(s1_rdvalid), .Done(s1_done), .dbg_state_o(dbg1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic          idle;
    logic [1:0]    cs;
    logic [AW-1:0] addr;
    logic          rw;
    logic          ab;
    logic [DW-1:0] dout;
    logic [DW-1:0] rd;
    logic          rv;
    logic          done;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  bit   model_on = 0;
  logic [AW-1:0] m_addr;
  logic          m_ab;
  logic [DW-1:0] m_dout, m_rd;

  function automatic rec_t idle_rec();
    rec_t r;
    r.idle = 1'b1; r.cs = 2'b00; r.addr = m_addr; r.rw = 1'b1; r.ab = m_ab;
    r.dout = m_dout; r.rd = m_rd; r.rv = 1'b0; r.done = 1'b0;
    return r;
  endfunction

  // Expand one command: per beat one SETUP, SC strobe cycles, one HOLD.
  function automatic void push_cmd(input logic rw, input logic chip, input logic ab,
                                   input logic [AW-1:0] a, input logic [1:0] len,
                                   input logic [DW-1:0] d);
    rec_t r;
    logic [AW-1:0] ba;
    if (!rw) m_dout = d;
    m_ab = ab;
    for (int b = 0; b <= int'(len); b++) begin
      ba = AW'((int'(a) + b) % (1 << AW));
      r.idle = 1'b0; r.addr = ba; r.rw = rw; r.ab = ab; r.dout = m_dout;
      r.rd = m_rd; r.rv = 1'b0; r.done = 1'b0; r.cs = 2'b00;
      exp_q.push_back(r);
      r.cs = chip ? 2'b10 : 2'b01;
      for (int s = 0; s < SC; s++) exp_q.push_back(r);
      r.cs = 2'b00;
      if (rw) begin
        m_rd = mem[ba];
        r.rd = m_rd;
        r.rv = 1'b1;
      end
      r.done = (b == int'(len));
      exp_q.push_back(r);
      m_addr = ba;
    end
  endfunction

  // Advance the model one cycle: reset, continue a command, accept, or idle.
  always @(posedge Clk) begin
    if (!Reset) begin
      exp_q.delete();
      m_addr = '0; m_ab = 1'b0; m_dout = '0; m_rd = '0;
      cur = idle_rec();
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (cur.idle && CmdValid) begin
      push_cmd(CmdRW, CmdChip, CmdAB, CmdAddr, CmdLen, CmdData);
      cur = exp_q.pop_front();
    end else begin
      cur = idle_rec();
    end
    model_on = 1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (model_on) begin
      check("cycle", {4'd0, CmdReady, CS, Address, RW, AB, DataOut, RdData, RdValid, Done},
            {4'd0, (cur.idle ? Reset : 1'b0), cur.cs, cur.addr, cur.rw, cur.ab,
             cur.dout, cur.rd, cur.rv, cur.done});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rw, input logic chip, input logic ab,
                       input logic [AW-1:0] a, input logic [1:0] len, input logic [DW-1:0] d);
    int n = 0;
    @(posedge Clk); #1;
    CmdRW = rw; CmdChip = chip; CmdAB = ab; CmdAddr = a; CmdLen = len; CmdData = d;
    CmdValid = 1'b1;
    @(negedge Clk);
    while (!CmdReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("accept_ready", {31'd0, CmdReady}, 32'd1);
    @(posedge Clk); #1;
    CmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (!CmdReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("idle_timeout", {31'd0, CmdReady}, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int rv_cnt, done_cnt, done_at;
    logic [AW-1:0] hold_addr [4];
    Reset = 1'b0;
    CmdValid = 1'b0; CmdRW = 1'b0; CmdChip = 1'b0; CmdAB = 1'b0;
    CmdAddr = '0; CmdLen = '0; CmdData = '0;
    s1_valid = 1'b0; s1_rw = 1'b0; s1_chip = 1'b0; s1_ab = 1'b0;
    s1_addr = '0; s1_len = '0; s1_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = DW'(i * 37 + 11);
    mem[3] = 8'h3C;

    // reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_addr", 32'(Address), 32'd0);
    check("rst_rw", 32'(RW), 32'd1);
    check("rst_cs", 32'(CS), 32'd0);
    check("rst_ready", 32'(CmdReady), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("rel_ready", 32'(CmdReady), 32'd1);

    // single write: chip 0, AB 1, addr 5, data A5
    issue(1'b0, 1'b0, 1'b1, 5'd5, 2'd0, 8'hA5);
    @(negedge Clk); // c1
    check("w_c1_cs", 32'(CS), 32'd0);
    check("w_c1_rw", 32'(RW), 32'd0);
    check("w_c1_addr", 32'(Address), 32'd5);
    check("w_c1_dout", 32'(DataOut), 32'hA5);
    @(negedge Clk); check("w_c2_cs", 32'(CS), 32'd1);
    @(negedge Clk); check("w_c3_cs", 32'(CS), 32'd1);
    @(negedge Clk);
    check("w_c4_cs", 32'(CS), 32'd0);
    check("w_c4_done", 32'(Done), 32'd1);
    @(negedge Clk);
    check("w_c5_ready", 32'(CmdReady), 32'd1);
    check("w_c5_done", 32'(Done), 32'd0);

    // single read: chip 1, addr 3
    issue(1'b1, 1'b1, 1'b0, 5'd3, 2'd0, 8'h00);
    @(negedge Clk); // c1
    @(negedge Clk); check("r_c2_cs", 32'(CS), 32'd2);
    @(negedge Clk); check("r_c3_cs", 32'(CS), 32'd2);
    @(negedge Clk);
    check("r_c4_rddata", 32'(RdData), 32'h3C);
    check("r_c4_rdvalid", 32'(RdValid), 32'd1);
    check("r_c4_done", 32'(Done), 32'd1);
    @(negedge Clk);
    check("r_c5_rdvalid", 32'(RdValid), 32'd0);

    // wrapping burst read: addr 30, 4 beats
    issue(1'b1, 1'b0, 1'b0, 5'd30, 2'd3, 8'h00);
    rv_cnt = 0; done_cnt = 0; done_at = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge Clk);
      if (RdValid) rv_cnt++;
      if (Done) begin done_cnt++; done_at = cyc; end
      if (cyc % 4 == 0) hold_addr[cyc / 4 - 1] = Address;
    end
    check("b_addr0", 32'(hold_addr[0]), 32'd30);
    check("b_addr1", 32'(hold_addr[1]), 32'd31);
    check("b_addr2", 32'(hold_addr[2]), 32'd0);
    check("b_addr3", 32'(hold_addr[3]), 32'd1);
    check("b_rvcnt", 32'(rv_cnt), 32'd4);
    check("b_donecnt", 32'(done_cnt), 32'd1);
    check("b_doneat", 32'(done_at), 32'd16);

    // reset during second-beat strobe of a 3-beat write
    issue(1'b0, 1'b1, 1'b1, 5'd10, 2'd2, 8'h77);
    repeat (5) @(negedge Clk); // c1..c5
    @(posedge Clk); #1;        // into c6 (second-beat strobe)
    Reset = 1'b0;
    @(negedge Clk);
    check("mr_c6_cs", 32'(CS), 32'd2);
    @(negedge Clk);            // c7, after the reset edge
    check("mr_c7_cs", 32'(CS), 32'd0);
    check("mr_c7_addr", 32'(Address), 32'd0);
    check("mr_c7_ready", 32'(CmdReady), 32'd0);
    check("mr_c7_done", 32'(Done), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("mr_rel_ready", 32'(CmdReady), 32'd1);

    // busy ignore: second command held valid throughout the first
    @(posedge Clk); #1;
    CmdRW = 1'b0; CmdChip = 1'b0; CmdAB = 1'b0; CmdAddr = 5'd7; CmdLen = 2'd0;
    CmdData = 8'h5A; CmdValid = 1'b1;
    @(negedge Clk);
    check("bz_c0_ready", 32'(CmdReady), 32'd1);
    @(posedge Clk); #1;
    CmdAddr = 5'd20; CmdData = 8'h11;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      check("bz_busy_addr", 32'(Address), 32'd7);
    end
    @(negedge Clk);
    check("bz_c5_ready", 32'(CmdReady), 32'd1);
    check("bz_c5_addr", 32'(Address), 32'd7);
    @(posedge Clk); #1;
    CmdValid = 1'b0;
    @(negedge Clk);
    check("bz_2nd_addr", 32'(Address), 32'd20);
    check("bz_2nd_dout", 32'(DataOut), 32'h11);
    wait_idle();

    // a few more commands checked by the model alone
    issue(1'b0, 1'b1, 1'b0, 5'd31, 2'd1, 8'hC3);
    wait_idle();
    issue(1'b1, 1'b0, 1'b1, 5'd0, 2'd2, 8'h00);
    wait_idle();

    // STROBE_CYCLES = 1: single read, chip 1, addr 3
    @(posedge Clk); #1;
    s1_rw = 1'b1; s1_chip = 1'b1; s1_ab = 1'b0; s1_addr = 5'd3; s1_len = 2'd0;
    s1_valid = 1'b1;
    @(negedge Clk);
    check("s1_c0_ready", 32'(s1_ready), 32'd1);
    @(posedge Clk); #1;
    s1_valid = 1'b0;
    @(negedge Clk); check("s1_c1_cs", 32'(s1_cs), 32'd0);
    @(negedge Clk); check("s1_c2_cs", 32'(s1_cs), 32'd2);
    @(negedge Clk);
    check("s1_c3_cs", 32'(s1_cs), 32'd0);
    check("s1_c3_done", 32'(s1_done), 32'd1);
    check("s1_c3_rdvalid", 32'(s1_rdvalid), 32'd1);
    check("s1_c3_rddata", 32'(s1_rddata), 32'h3C);
    @(negedge Clk);
    check("s1_c4_ready", 32'(s1_ready), 32'd1);

    repeat (3) @(posedge Clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reg_bus_master.md
REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter SIZE, default 5, meaning register address width.
REQ-002 SHALL have parameter DATASIZE, default 8, meaning register data width.
REQ-003 SHALL have parameter STROBE_CYCLES, default 2, meaning chip-select active cycles per beat (legal 1..7).
REQ-004 SHALL have port Clk  input  1  the single clock; all logic on the rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port CmdValid  input  1  command request.
REQ-007 SHALL have port CmdReady  output  1  master accepts a command this cycle.
REQ-008 SHALL have port CmdRW  input  1  1 = read, 0 = write.
REQ-009 SHALL have port CmdChip  input  1  target chip: 0 drives CS=01, 1 drives CS=10.
REQ-010 SHALL have port CmdAB  input  1  bank select forwarded to AB.
REQ-011 SHALL have port CmdAddr  input  SIZE  start address.
REQ-012 SHALL have port CmdLen  input  2  burst beats minus one (1..4 beats).
REQ-013 SHALL have port CmdData  input  DATASIZE  write data, used for every write beat.
REQ-014 SHALL have ports Address (output, SIZE), RW (output, 1), CS (output, 2), AB (output, 1), DataOut (output, DATASIZE): register-bus drive, all registered.
REQ-015 SHALL have port DataIn  input  DATASIZE  read data from the addressed register.
REQ-016 SHALL have ports RdData (output, DATASIZE) and RdValid (output, 1): captured read beat.
REQ-017 SHALL have port Done  output  1  one-cycle pulse marking the final beat of a command.

Function
REQ-018 SHALL implement states IDLE, SETUP, STROBE, HOLD; CmdReady = 1 only in IDLE.
REQ-019 SHALL accept a command on a rising edge with CmdValid=1 and CmdReady=1, latching all Cmd* inputs, and enter SETUP next cycle.
REQ-020 SHALL, in SETUP (1 cycle), drive Address, AB, RW=CmdRW and DataOut (writes) with CS=00.
REQ-021 SHALL, in STROBE (STROBE_CYCLES cycles, counted by an internal counter), drive CS per CmdChip with Address/AB/RW/DataOut held.
REQ-022 SHALL, for reads, capture DataIn at the edge ending the last STROBE cycle into RdData and assert RdValid for exactly the following HOLD cycle.
REQ-023 SHALL, in HOLD (1 cycle), drive CS=00 with Address/AB/RW/DataOut held.
REQ-024 SHALL, after HOLD, go to SETUP with Address+1 if beats remain, else to IDLE.
REQ-025 SHALL wrap Address modulo 2^SIZE during bursts (31 -> 0 at SIZE=5).
REQ-026 SHALL assert Done during the HOLD cycle of the last beat only.
REQ-027 SHALL, in IDLE, drive CS=00, RW=1, hold Address/AB/DataOut/RdData at last values, RdValid=0, Done=0.
REQ-028 SHALL never drive CS=11; CS SHALL be 00 in every non-STROBE cycle.
REQ-029 SHALL give single-beat latency: accept edge at cycle 0, SETUP c1, STROBE c2..c(1+STROBE_CYCLES), HOLD c(2+STROBE_CYCLES) with Done, CmdReady again the cycle after.
REQ-030 SHALL ignore CmdValid and Cmd* changes while not in IDLE.

Reset
REQ-031 SHALL, on any edge with Reset=0, enter IDLE and set Address=0, RW=1, CS=00, AB=0, DataOut=0, RdData=0, RdValid=0, Done=0, counters=0.
REQ-032 SHALL abandon an in-flight command on reset mid-operation with no Done and no RdValid pulse; CS=00 from that edge.
REQ-033 SHALL keep CmdReady=0 while Reset=0 and assert it the first cycle after Reset returns to 1.

Verification
REQ-034 SHALL cover single write: CmdRW=0, CmdChip=0, AB=1, Addr=5, Data=8'hA5, Len=0 -> SETUP c1 CS=00 RW=0 Address=5; CS=01 c2-c3; HOLD c4 CS=00 Done=1; CmdReady=1 c5.
REQ-035 SHALL cover single read: CmdRW=1, CmdChip=1, Addr=3, DataIn=8'h3C during STROBE -> CS=10 c2-c3, RdData=8'h3C with RdValid=1 and Done=1 in c4.
REQ-036 SHALL cover wrap burst read: Addr=30, Len=3 -> Address 30,31,0,1 on successive beats, four RdValid pulses, Done only on fourth HOLD.
REQ-037 SHALL cover reset mid-burst: Reset=0 during second-beat STROBE -> next cycle CS=00, Address=0, CmdReady=0; no Done; CmdReady=1 one cycle after release.
REQ-038 SHALL cover busy ignore: new CmdValid with different Addr held throughout a write -> single command executed, Address unchanged, second command accepted only on return to IDLE.
REQ-039 SHALL cover STROBE_CYCLES=1: single read -> CS active exactly one cycle, Done in c3.
